// File: rtl/fp_addsub_controller.sv
// Sequencer for one FP add/subtract through an external shared mantissa shifter:
// right-shift align, add/sub, then left-shift normalise when the sum lost its leading one.
module fp_addsub_controller #(
    parameter int Mantissa_Size = 23,
    parameter int Exponent_Size = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     op,
    input  logic                     a_sign,
    input  logic                     b_sign,
    input  logic [Exponent_Size-1:0] a_exp,
    input  logic [Exponent_Size-1:0] b_exp,
    input  logic [Mantissa_Size:0]   a_man,
    input  logic [Mantissa_Size:0]   b_man,
    output logic                     sh_enable,
    output logic                     sh_load,
    output logic                     sh_direction,
    output logic [Mantissa_Size:0]   sh_mantissa,
    output logic [Exponent_Size-1:0] sh_exponent,
    output logic [Exponent_Size-1:0] sh_no_of_shifts,
    input  logic                     sh_done,
    input  logic [Mantissa_Size:0]   sh_man_in,
    input  logic [Exponent_Size-1:0] sh_exp_in,
    output logic                     busy,
    output logic                     result_valid,
    output logic                     res_sign,
    output logic [Exponent_Size-1:0] res_exp,
    output logic [Mantissa_Size:0]   res_man,
    output logic                     overflow
);
    localparam int M = Mantissa_Size;
    localparam int E = Exponent_Size;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_ALIGN_LD = 3'd1;
    localparam logic [2:0] S_ALIGN_WT = 3'd2;
    localparam logic [2:0] S_ADDSUB   = 3'd3;
    localparam logic [2:0] S_NORM_LD  = 3'd4;
    localparam logic [2:0] S_NORM_WT  = 3'd5;
    localparam logic [2:0] S_DONE     = 3'd6;

    logic [2:0]   state_q,    state_d;
    logic         x_sign_q,   x_sign_d;
    logic         eff_sub_q,  eff_sub_d;
    logic [E-1:0] x_exp_q,    x_exp_d;
    logic [E-1:0] y_exp_q,    y_exp_d;
    logic [M:0]   x_man_q,    x_man_d;
    logic [M:0]   y_man_q,    y_man_d;
    logic [M:0]   s_man_q,    s_man_d;
    logic         res_sign_q, res_sign_d;
    logic [E-1:0] res_exp_q,  res_exp_d;
    logic [M:0]   res_man_q,  res_man_d;
    logic         ovf_q,      ovf_d;

    logic         a_ge_b;
    logic         b_eff_sign;
    logic [M+1:0] sum;
    logic [E:0]   exp_inc;
    logic         in_align;
    logic         in_norm;

    // Larger magnitude becomes X so the subtraction below can never go negative.
    assign a_ge_b     = (a_exp > b_exp) || ((a_exp == b_exp) && (a_man >= b_man));
    assign b_eff_sign = b_sign ^ op;
    assign sum        = eff_sub_q ? ({1'b0, x_man_q} - {1'b0, y_man_q})
                                  : ({1'b0, x_man_q} + {1'b0, y_man_q});
    assign exp_inc    = {1'b0, x_exp_q} + {{E{1'b0}}, 1'b1};

    always_comb begin
        state_d    = state_q;
        x_sign_d   = x_sign_q;
        eff_sub_d  = eff_sub_q;
        x_exp_d    = x_exp_q;
        y_exp_d    = y_exp_q;
        x_man_d    = x_man_q;
        y_man_d    = y_man_q;
        s_man_d    = s_man_q;
        res_sign_d = res_sign_q;
        res_exp_d  = res_exp_q;
        res_man_d  = res_man_q;
        ovf_d      = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    ovf_d = 1'b0;
                    if (a_ge_b) begin
                        x_sign_d = a_sign;
                        x_exp_d  = a_exp;
                        x_man_d  = a_man;
                        y_exp_d  = b_exp;
                        y_man_d  = b_man;
                    end else begin
                        x_sign_d = b_eff_sign;
                        x_exp_d  = b_exp;
                        x_man_d  = b_man;
                        y_exp_d  = a_exp;
                        y_man_d  = a_man;
                    end
                    eff_sub_d = a_sign ^ b_eff_sign;
                    state_d   = S_ALIGN_LD;
                end
            end
            S_ALIGN_LD: state_d = S_ALIGN_WT;
            S_ALIGN_WT: begin
                if (sh_done) begin
                    y_man_d = sh_man_in;
                    state_d = S_ADDSUB;
                end
            end
            S_ADDSUB: begin
                res_sign_d = x_sign_q;
                if (sum[M+1]) begin
                    // Carry out: drop the LSB, bump the exponent; wrap flags overflow.
                    res_man_d = sum[M+1:1];
                    res_exp_d = exp_inc[E-1:0];
                    ovf_d     = exp_inc[E];
                    state_d   = S_DONE;
                end else if (sum == '0) begin
                    res_man_d  = '0;
                    res_exp_d  = '0;
                    res_sign_d = 1'b0;
                    state_d    = S_DONE;
                end else if (sum[M]) begin
                    res_man_d = sum[M:0];
                    res_exp_d = x_exp_q;
                    state_d   = S_DONE;
                end else begin
                    s_man_d = sum[M:0];
                    state_d = S_NORM_LD;
                end
            end
            S_NORM_LD: state_d = S_NORM_WT;
            S_NORM_WT: begin
                if (sh_done) begin
                    res_man_d  = sh_man_in;
                    res_exp_d  = sh_exp_in;
                    res_sign_d = x_sign_q;
                    state_d    = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            x_sign_q   <= 1'b0;
            eff_sub_q  <= 1'b0;
            x_exp_q    <= '0;
            y_exp_q    <= '0;
            x_man_q    <= '0;
            y_man_q    <= '0;
            s_man_q    <= '0;
            res_sign_q <= 1'b0;
            res_exp_q  <= '0;
            res_man_q  <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            x_sign_q   <= x_sign_d;
            eff_sub_q  <= eff_sub_d;
            x_exp_q    <= x_exp_d;
            y_exp_q    <= y_exp_d;
            x_man_q    <= x_man_d;
            y_man_q    <= y_man_d;
            s_man_q    <= s_man_d;
            res_sign_q <= res_sign_d;
            res_exp_q  <= res_exp_d;
            res_man_q  <= res_man_d;
            ovf_q      <= ovf_d;
        end
    end

    assign in_align = (state_q == S_ALIGN_LD) || (state_q == S_ALIGN_WT);
    assign in_norm  = (state_q == S_NORM_LD)  || (state_q == S_NORM_WT);

    assign sh_enable       = in_align || in_norm;
    assign sh_load         = (state_q == S_ALIGN_LD) || (state_q == S_NORM_LD);
    assign sh_direction    = in_align;
    assign sh_mantissa     = in_align ? y_man_q : (in_norm ? s_man_q : '0);
    assign sh_exponent     = in_align ? y_exp_q : (in_norm ? x_exp_q : '0);
    assign sh_no_of_shifts = in_align ? (x_exp_q - y_exp_q) : '0;

    assign busy         = (state_q != S_IDLE);
    assign result_valid = (state_q == S_DONE);
    assign res_sign     = res_sign_q;
    assign res_exp      = res_exp_q;
    assign res_man      = res_man_q;
    assign overflow     = ovf_q;
endmodule

// File: tb/tb_fp_addsub_controller.sv
// Scoreboard bench for fp_addsub_controller with a one-bit-per-cycle behavioural shifter.
module tb_fp_addsub_controller;
    localparam int M = 23;
    localparam int E = 8;

    logic         clk = 1'b0;
    logic         rst_n, start, op, a_sign, b_sign;
    logic [E-1:0] a_exp, b_exp;
    logic [M:0]   a_man, b_man;
    logic         sh_enable, sh_load, sh_direction, sh_done;
    logic [M:0]   sh_mantissa, sh_man_in;
    logic [E-1:0] sh_exponent, sh_no_of_shifts, sh_exp_in;
    logic         busy, result_valid, res_sign, overflow;
    logic [E-1:0] res_exp;
    logic [M:0]   res_man;

    typedef struct {
        logic         rs;
        logic [E-1:0] re;
        logic [M:0]   rm;
        logic         ro;
        int           loads;
        int           lat;
        int           ash;
        logic [M:0]   ym;
        logic [M:0]   sm;
        int           t0;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;

    fp_addsub_controller #(.Mantissa_Size(M), .Exponent_Size(E)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op),
        .a_sign(a_sign), .b_sign(b_sign), .a_exp(a_exp), .b_exp(b_exp),
        .a_man(a_man), .b_man(b_man),
        .sh_enable(sh_enable), .sh_load(sh_load), .sh_direction(sh_direction),
        .sh_mantissa(sh_mantissa), .sh_exponent(sh_exponent),
        .sh_no_of_shifts(sh_no_of_shifts), .sh_done(sh_done),
        .sh_man_in(sh_man_in), .sh_exp_in(sh_exp_in),
        .busy(busy), .result_valid(result_valid), .res_sign(res_sign),
        .res_exp(res_exp), .res_man(res_man), .overflow(overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Shifter model: right shifts count down one bit per cycle, left shifts until bit M is set.
    logic [M:0]   m_man;
    logic [E-1:0] m_exp, m_cnt;
    logic         m_dir;
    always @(posedge clk) begin
        if (!rst_n) begin
            m_man <= '0; m_exp <= '0; m_cnt <= '0; m_dir <= 1'b0;
        end else if (sh_enable && sh_load) begin
            m_man <= sh_mantissa; m_exp <= sh_exponent;
            m_cnt <= sh_no_of_shifts; m_dir <= sh_direction;
        end else if (sh_enable) begin
            if (m_dir) begin
                if (m_cnt != 0) begin
                    m_man <= m_man >> 1; m_exp <= m_exp + 1'b1; m_cnt <= m_cnt - 1'b1;
                end
            end else if (!m_man[M] && m_man != 0) begin
                m_man <= m_man << 1; m_exp <= m_exp - 1'b1;
            end
        end
    end
    assign sh_done   = sh_enable && !sh_load && (m_dir ? (m_cnt == 0) : (m_man[M] || m_man == 0));
    assign sh_man_in = m_man;
    assign sh_exp_in = m_exp;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, want);
        end
    endtask

    // Monitor: shifter-load sanity against the in-flight op, result compare on result_valid.
    initial begin
        int   loads = 0;
        logic prev_load = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                loads = 0;
                prev_load = 1'b0;
            end else begin
                if (sh_load) begin
                    loads++;
                    check("load_back_to_back", 32'(prev_load), 32'd0);
                    if (sb.size() > 0) begin
                        if (sh_direction) begin
                            check("align_shifts", 32'(sh_no_of_shifts), 32'(sb[0].ash));
                            check("align_mantissa", 32'(sh_mantissa), 32'(sb[0].ym));
                        end else begin
                            check("norm_mantissa", 32'(sh_mantissa), 32'(sb[0].sm));
                            check("norm_shifts", 32'(sh_no_of_shifts), 32'd0);
                        end
                    end
                end
                prev_load = sh_load;
                if (result_valid) begin
                    if (sb.size() == 0) begin
                        n_cmp++; n_err++;
                        $display("FAIL unexpected_result: got result_valid=1 want no result pending");
                    end else begin
                        e = sb.pop_front();
                        check("res_sign", 32'(res_sign), 32'(e.rs));
                        check("res_exp", 32'(res_exp), 32'(e.re));
                        check("res_man", 32'(res_man), 32'(e.rm));
                        check("overflow", 32'(overflow), 32'(e.ro));
                        check("sh_loads", 32'(loads), 32'(e.loads));
                        check("latency", 32'(cyc - e.t0), 32'(e.lat));
                    end
                    loads = 0;
                end
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (busy && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (busy) check("idle_timeout", 32'(busy), 32'd0);
    endtask

    task automatic drive(input logic as_, input logic [E-1:0] ae, input logic [M:0] am,
                         input logic bs, input logic [E-1:0] be, input logic [M:0] bm, input logic o);
        a_sign = as_; a_exp = ae; a_man = am;
        b_sign = bs;  b_exp = be; b_man = bm; op = o; start = 1'b1;
    endtask

    task automatic run_op(input logic as_, input logic [E-1:0] ae, input logic [M:0] am,
                          input logic bs, input logic [E-1:0] be, input logic [M:0] bm, input logic o,
                          input logic rs, input logic [E-1:0] re, input logic [M:0] rm, input logic ro,
                          input int ld, input int lat, input int ash, input logic [M:0] ym,
                          input logic [M:0] sm);
        exp_t e;
        wait_idle();
        drive(as_, ae, am, bs, be, bm, o);
        e.rs = rs; e.re = re; e.rm = rm; e.ro = ro; e.loads = ld; e.lat = lat;
        e.ash = ash; e.ym = ym; e.sm = sm; e.t0 = cyc;
        sb.push_back(e);
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic garbage_start();
        drive(1'b1, 8'd200, 24'hFFFFFF, 1'b0, 8'd1, 24'h800001, 1'b1);
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    initial begin
        int n;
        rst_n = 1'b0; start = 1'b0; op = 1'b0;
        a_sign = 1'b0; b_sign = 1'b0; a_exp = '0; b_exp = '0; a_man = '0; b_man = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_result_valid", 32'(result_valid), 32'd0);
        check("rst_sh_enable", 32'(sh_enable), 32'd0);
        check("rst_res_man", 32'(res_man), 32'd0);
        rst_n = 1'b1;

        // 1.0 + 1.0
        run_op(0, 127, 24'h800000, 0, 127, 24'h800000, 0, 0, 128, 24'h800000, 0, 1, 4, 0, 24'h800000, 0);
        // 1.5 + 0.25, with a start pulse during alignment that must be ignored
        run_op(0, 127, 24'hC00000, 0, 125, 24'h800000, 0, 0, 127, 24'hE00000, 0, 1, 6, 2, 24'h800000, 0);
        repeat (2) @(negedge clk);
        garbage_start();
        // 1.0 - 0.75, then a start in the DONE cycle that must be ignored
        run_op(0, 127, 24'h800000, 0, 126, 24'hC00000, 1, 0, 125, 24'h800000, 0, 2, 9, 1, 24'hC00000, 24'h200000);
        n = 0;
        while (!result_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!result_valid) check("done_timeout", 32'(result_valid), 32'd1);
        garbage_start();
        // 1.0 - 1.0
        run_op(0, 127, 24'h800000, 0, 127, 24'h800000, 1, 0, 0, 24'h000000, 0, 1, 4, 0, 24'h800000, 0);
        // big exponent gap: Y shifted out entirely
        run_op(0, 157, 24'h800000, 0, 127, 24'h800000, 0, 0, 157, 24'h800000, 0, 1, 34, 30, 24'h800000, 0);
        // 0.25 - 1.0 = -0.75 (operand swap)
        run_op(0, 125, 24'h800000, 0, 127, 24'h800000, 1, 1, 126, 24'hC00000, 0, 2, 9, 2, 24'h800000, 24'h600000);
        // exponent 255 carry wraps -> overflow
        run_op(0, 255, 24'h800000, 0, 255, 24'h800000, 0, 0, 0, 24'h800000, 1, 1, 4, 0, 24'h800000, 0);
        // -1.5 + -1.5 (overflow must clear)
        run_op(1, 127, 24'hC00000, 1, 127, 24'hC00000, 0, 1, 128, 24'hC00000, 0, 1, 4, 0, 24'hC00000, 0);
        // 1.0 - (-1.0)
        run_op(0, 127, 24'h800000, 1, 127, 24'h800000, 1, 0, 128, 24'h800000, 0, 1, 4, 0, 24'h800000, 0);
        // 1.0 - 1.5: mantissa tie-break picks B
        run_op(0, 127, 24'h800000, 0, 127, 24'hC00000, 1, 1, 126, 24'h800000, 0, 2, 7, 0, 24'h800000, 24'h400000);

        // reset in the middle of a long alignment
        wait_idle();
        drive(0, 157, 24'h800000, 0, 127, 24'h800000, 0);
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_sh_enable", 32'(sh_enable), 32'd0);
        check("abort_sh_mantissa", 32'(sh_mantissa), 32'd0);
        check("abort_result_valid", 32'(result_valid), 32'd0);
        check("abort_res_sign", 32'(res_sign), 32'd0);
        check("abort_res_exp", 32'(res_exp), 32'd0);
        check("abort_res_man", 32'(res_man), 32'd0);
        rst_n = 1'b1;

        // 1.0 + 1.5 after recovery
        run_op(0, 127, 24'h800000, 0, 127, 24'hC00000, 0, 0, 128, 24'hA00000, 0, 1, 4, 0, 24'h800000, 0);

        n = 0;
        while (sb.size() > 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("scoreboard_drain", 32'(sb.size()), 32'd0);
        repeat (5) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
